// File: rtl/adc_value_decimator.sv
// rtl/adc_value_decimator.sv - ADC value register, 2^DEC_LOG2 block averager and show-ahead output FIFO.
// Downstream of the tracking-ADC up/down FSM; ADC_value_o feeds back to the FSM.

module adc_value_decimator #(
    parameter int W          = 16,
    parameter int DEC_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [W-1:0]                  next_value_i,
    input  logic                          enable_i,
    output logic [W-1:0]                  ADC_value_o,
    output logic [W-1:0]                  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_ovf_i
);

    localparam int AW = W + DEC_LOG2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]        adc_q, adc_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic [W-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [W-1:0]        hold_q, hold_d;
    logic                ovf_q, ovf_d;

    logic [AW-1:0]       sum;
    logic [W-1:0]        avg;
    logic                block_done;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // The accumulator is DEC_LOG2 bits wider than a sample, so a full block of
    // full-scale samples cannot wrap; the upper W bits are the floored average.
    assign sum        = acc_q + AW'(next_value_i);
    assign avg        = sum[AW-1:DEC_LOG2];
    assign block_done = enable_i && (&cnt_q);

    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign pop        = !fifo_empty && out_ready;
    assign push_ok    = block_done && (!fifo_full || pop);
    assign drop       = block_done && fifo_full && !pop;

    always_comb begin
        adc_d = adc_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (enable_i) begin
            adc_d = next_value_i;
            cnt_d = cnt_q + DEC_LOG2'(1);
            acc_d = block_done ? '0 : sum;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = hold_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            adc_q    <= adc_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    // When full with a same-cycle pop, wr_ptr equals rd_ptr: the head is read
    // combinationally before this edge overwrites its slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= avg;
        end
    end

    assign ADC_value_o = adc_q;
    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_empty ? hold_q : mem_q[rd_ptr_q];
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;

endmodule
